// File: rtl/io_port_bridge.sv
// Host-to-datapath port bridge: paced host writes onto dp_in, plus capture of
// every dp_out change into a FIFO that the host drains.
module io_port_bridge #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] dp_out,
  output logic [15:0] dp_in,
  input  logic [15:0] host_in_data,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  output logic [15:0] host_out_data,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  output logic [4:0]  count,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
  localparam logic [4:0]    FULL_CNT  = 5'(DEPTH);

  logic [15:0]   r_dp_in;
  logic [HW-1:0] r_hold;
  logic [15:0]   r_prev;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_count;
  logic          r_overflow;

  logic w_in_ready;
  logic w_in_hs;
  logic w_change;
  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_drop;

  assign w_in_ready = (r_hold == HW'(0));
  assign w_in_hs    = host_in_valid && w_in_ready;
  assign w_change   = (dp_out != r_prev);
  assign w_pop      = (r_count != 5'd0) && host_out_ready;
  assign w_full     = (r_count == FULL_CNT);
  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign w_push_ok  = w_change && (!w_full || w_pop);
  assign w_drop     = w_change && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_dp_in <= 16'h0000;
      r_hold  <= HW'(0);
    end else if (w_in_hs) begin
      r_dp_in <= host_in_data;
      r_hold  <= HOLD_LOAD;
    end else if (r_hold != HW'(0)) begin
      r_hold  <= r_hold - HW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_prev     <= 16'h0000;
      r_wptr     <= AW'(0);
      r_rptr     <= AW'(0);
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      r_prev <= dp_out;
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - 5'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge CLK) begin
    if (reset && w_push_ok) begin
      r_mem[r_wptr] <= dp_out;
    end
  end

  assign dp_in          = r_dp_in;
  assign host_in_ready  = w_in_ready;
  assign host_out_valid = (r_count != 5'd0);
  assign host_out_data  = (r_count != 5'd0) ? r_mem[r_rptr] : 16'h0000;
  assign count          = r_count;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed and random stimulus for io_port_bridge, checked every cycle against
// a queue-based reference model.
module tb_io_port_bridge;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;

  logic        CLK;
  logic        reset;
  logic [15:0] dp_out;
  logic [15:0] dp_in;
  logic [15:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [4:0]  count;
  logic        overflow;

  io_port_bridge #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .CLK(CLK), .reset(reset), .dp_out(dp_out), .dp_in(dp_in),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .host_out_data(host_out_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .count(count), .overflow(overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] m_dp_in = 16'h0000;
  logic [15:0] m_prev  = 16'h0000;
  logic        m_ovf   = 1'b0;
  logic        m_ready = 1'b1;
  int          edge_idx = 0;
  int          last_hs  = -100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the bridge's rules to the inputs present before the coming edge.
  task automatic model_edge();
    logic pop;
    if (!reset) begin
      q.delete();
      m_dp_in = 16'h0000;
      m_prev  = 16'h0000;
      m_ovf   = 1'b0;
      last_hs = edge_idx + 1 - HOLD;
    end else begin
      if (host_in_valid && m_ready) begin
        m_dp_in = host_in_data;
        last_hs = edge_idx + 1;
      end
      pop = (q.size() != 0) && host_out_ready;
      if (pop) void'(q.pop_front());
      if (dp_out != m_prev) begin
        if (q.size() < DEPTH) q.push_back(dp_out);
        else m_ovf = 1'b1;
      end
      m_prev = dp_out;
    end
  endtask

  task automatic check_all();
    chk("dp_in", 32'(dp_in), 32'(m_dp_in));
    chk("in_ready", 32'(host_in_ready), 32'(m_ready));
    chk("out_valid", 32'(host_out_valid), 32'(q.size() != 0));
    chk("out_data", 32'(host_out_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk("count", 32'(count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    edge_idx++;
    m_ready = ((edge_idx - last_hs) >= (HOLD - 1));
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    dp_out = 16'h0000;
    host_in_data = 16'h0000;
    host_in_valid = 1'b0;
    host_out_ready = 1'b0;

    // Reset state
    repeat (10) step();
    chk("rst_ready", 32'(host_in_ready), 32'h1);
    chk("rst_valid", 32'(host_out_valid), 32'h0);
    chk("rst_data", 32'(host_out_data), 32'h0);

    // Paced input handshake
    reset = 1'b1;
    host_in_valid = 1'b1;
    host_in_data = 16'hABCD;
    step();
    chk("dp_in_abcd", 32'(dp_in), 32'hABCD);
    chk("hold_low1", 32'(host_in_ready), 32'h0);
    host_in_data = 16'h1111;
    step();
    chk("hold_low2", 32'(host_in_ready), 32'h0);
    step();
    chk("hold_low3", 32'(host_in_ready), 32'h0);
    chk("dp_in_held", 32'(dp_in), 32'hABCD);
    host_in_valid = 1'b0;
    step();
    chk("hold_high4", 32'(host_in_ready), 32'h1);

    // Two changes captured in order
    dp_out = 16'h0000; step();
    dp_out = 16'h1234; step();
    dp_out = 16'h1234; step();
    dp_out = 16'hBEEF; step();
    chk("two_count", 32'(count), 32'd2);
    chk("two_head", 32'(host_out_data), 32'h1234);
    host_out_ready = 1'b1;
    step();
    chk("two_second", 32'(host_out_data), 32'hBEEF);
    step();
    chk("two_empty", 32'(count), 32'd0);
    host_out_ready = 1'b0;

    // Overflow: ninth value dropped
    for (int i = 1; i <= 9; i++) begin
      dp_out = 16'h1000 + 16'(i);
      step();
    end
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'h1);
    host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", 32'(host_out_data), 32'h1000 + 32'(i));
      step();
    end
    chk("ovf_drained", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    host_out_ready = 1'b0;

    // Full plus simultaneous pop accepts the new value
    reset = 1'b0; dp_out = 16'h0000; step();
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      dp_out = 16'h2000 + 16'(i);
      step();
    end
    dp_out = 16'h2009;
    host_out_ready = 1'b1;
    step();
    chk("fullpop_count", 32'(count), 32'd8);
    chk("fullpop_ovf", 32'(overflow), 32'h0);
    for (int i = 2; i <= 9; i++) begin
      chk("fullpop_order", 32'(host_out_data), 32'h2000 + 32'(i));
      step();
    end
    chk("fullpop_empty", 32'(count), 32'd0);
    host_out_ready = 1'b0;

    // Reset mid-transfer discards FIFO and hold
    for (int i = 1; i <= 5; i++) begin
      dp_out = 16'h3000 + 16'(i);
      step();
    end
    host_in_valid = 1'b1;
    host_in_data = 16'h5555;
    step();
    chk("mid_hold", 32'(host_in_ready), 32'h0);
    reset = 1'b0;
    step();
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(host_out_valid), 32'h0);
    chk("mid_dp_in", 32'(dp_in), 32'h0);
    chk("mid_ready", 32'(host_in_ready), 32'h1);
    host_in_valid = 1'b0;

    // Steady nonzero dp_out at reset release captured exactly once
    dp_out = 16'hDEAD;
    step();
    reset = 1'b1;
    step();
    chk("dead_count", 32'(count), 32'd1);
    chk("dead_data", 32'(host_out_data), 32'hDEAD);
    repeat (4) step();
    chk("dead_once", 32'(count), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      host_in_valid = 1'($urandom_range(0, 1));
      host_in_data = 16'($urandom);
      host_out_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) dp_out = 16'($urandom_range(0, 5));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
